// File: rtl/mips_defs.sv
`default_nettype none
//============================================================================
// Package  : mips_defs
// Brief    : Shared MIPS32 core constants and the fetch buffer entry type.
// Revision : 1.0
//============================================================================
package mips_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INST_W           = 32;
  localparam int          ROM_ADDR_W       = 14;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
//============================================================================
// Module   : fetch_fifo
// Brief    : 2-entry {pc, inst} buffer between the ROM response and decode.
// Revision : 1.0
//============================================================================
module fetch_fifo
  import mips_defs::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic [1:0]   count
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wr_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rd_entry = r_mem[r_rd_ptr];
  assign count    = r_count;

  // The issuer's credit check must make overflow and underflow unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && r_count == 2'd2));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && r_count == 2'd0));

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
//============================================================================
// Module   : inst_fetch
// Brief    : PC owner and ROM initiator; buffers fetched words for decode.
// Revision : 1.0
//============================================================================
module inst_fetch
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc
);

  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic         r_run;
  logic         r_req;
  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  logic [1:0]   w_count;
  logic [2:0]   w_credit;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_head;

  assign w_pop      = inst_valid & inst_ready;
  assign inst_valid = (w_count != 2'd0) & ~redirect_valid;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

  // Slots already committed: buffered words plus the one in flight, less the
  // one leaving this cycle. A new request is only legal if it still fits.
  assign w_credit = {1'b0, w_count} + {2'b00, r_req} - {2'b00, w_pop};
  assign w_issue  = r_run & ~redirect_valid & (w_credit < 3'd2);
  assign rom_en   = w_issue;
  assign rom_addr = r_pc[ADDR_W+1:2];

  assign w_push          = r_req & ~redirect_valid;
  assign w_wr_entry.pc   = r_req_pc;
  assign w_wr_entry.inst = rom_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_req_pc <= RESET_PC;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_pc  <= align_pc(redirect_pc);
        r_req <= 1'b0;
      end else begin
        r_req <= w_issue;
        if (w_issue) begin
          r_req_pc <= r_pc;
          r_pc     <= r_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .wr_entry (w_wr_entry),
    .rd_entry (w_head),
    .count    (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
//============================================================================
// Module   : tb_inst_fetch
// Brief    : Scoreboard bench for inst_fetch against a synchronous ROM model.
// Revision : 1.0
//============================================================================
module tb_inst_fetch;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data = 32'h0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  // Single-cycle synchronous ROM; word n holds 0x1000_0000 + n, 0 when idle.
  always @(posedge clk) begin
    rom_data <= rom_en ? (32'h1000_0000 + {18'b0, rom_addr}) : 32'h0;
  end

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return 32'h1000_0000 + {18'b0, pc[15:2]};
  endfunction

  function automatic void push_seq(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 32'(4 * i);
      e.inst = exp_word(e.pc);
      exp_q.push_back(e);
    end
  endfunction

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no instruction", inst_pc, inst);
      end else begin
        mon_e = exp_q.pop_front();
        if (inst_pc !== mon_e.pc || inst !== mon_e.inst) begin
          n_fail++;
          $display("FAIL sb_stream: got pc=%h inst=%h, required pc=%h inst=%h",
                   inst_pc, inst, mon_e.pc, mon_e.inst);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL rst_rom_en: got %b, required 0", rom_en); end
    n_cmp++; if (rom_addr !== 14'h0) begin n_fail++; $display("FAIL rst_rom_addr: got %h, required 0", rom_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h, required 0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h, required 0", inst_pc); end
    exp_q.delete(); push_seq(32'h0, 64);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); // cycle 0, before E0
    n_cmp++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL run_gate: got rom_en=%b, required 0", rom_en); end
    @(negedge clk); // cycle 1
    n_cmp++; if (rom_en !== 1'b1 || rom_addr !== 14'h0) begin n_fail++; $display("FAIL first_req: got en=%b addr=%h, required en=1 addr=0", rom_en, rom_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL c1_valid: got %b, required 0", inst_valid); end
    @(negedge clk); // cycle 2
    n_cmp++; if (inst_valid !== 1'b0 || rom_addr !== 14'h1) begin n_fail++; $display("FAIL c2: got valid=%b addr=%h, required valid=0 addr=1", inst_valid, rom_addr); end
    @(negedge clk); // cycle 3
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL c3_first: got valid=%b pc=%h, required valid=1 pc=0", inst_valid, inst_pc); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); // cycle 4
    @(posedge clk); #1 inst_ready = 1'b0; // cycles 5..9 stalled
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'h1000_0002) begin n_fail++; $display("FAIL stall_hold c%0d: got valid=%b pc=%h inst=%h, required 1/8/10000002", c, inst_valid, inst_pc, inst); end
      n_cmp++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL stall_rom_en c%0d: got %b, required 0", c, rom_en); end
    end
    @(posedge clk); #1 inst_ready = 1'b1;
    @(negedge clk); // cycle 10: one slot freed, fetch resumes at pc 16
    n_cmp++; if (rom_en !== 1'b1 || rom_addr !== 14'h4) begin n_fail++; $display("FAIL resume: got en=%b addr=%h, required en=1 addr=4", rom_en, rom_addr); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_redirect();
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    exp_q.delete(); push_seq(32'h100, 64);
    @(negedge clk); // t
    n_cmp++; if (inst_valid !== 1'b0 || rom_en !== 1'b0) begin n_fail++; $display("FAIL redir_t: got valid=%b en=%b, required 0/0", inst_valid, rom_en); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk); // t+1
    n_cmp++; if (rom_en !== 1'b1 || rom_addr !== 14'h40 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_t1: got en=%b addr=%h valid=%b, required 1/40/0", rom_en, rom_addr, inst_valid); end
    @(negedge clk); // t+2
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_t2: got valid=%b, required 0", inst_valid); end
    @(negedge clk); // t+3
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin n_fail++; $display("FAIL redir_t3: got valid=%b pc=%h, required 1/100", inst_valid, inst_pc); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back_redirect();
    @(posedge clk); #1 inst_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
    exp_q.delete(); push_seq(32'h300, 64);
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0 || rom_en !== 1'b0) begin n_fail++; $display("FAIL b2b_r1: got valid=%b en=%b, required 0/0", inst_valid, rom_en); end
    @(posedge clk); #1 redirect_pc = 32'h300;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0 || rom_en !== 1'b0) begin n_fail++; $display("FAIL b2b_r2: got valid=%b en=%b, required 0/0", inst_valid, rom_en); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (rom_en !== 1'b1 || rom_addr !== 14'hC0) begin n_fail++; $display("FAIL b2b_req: got en=%b addr=%h, required 1/c0", rom_en, rom_addr); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin n_fail++; $display("FAIL b2b_first: got valid=%b pc=%h, required 1/300", inst_valid, inst_pc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_q.delete(); push_seq(32'hFFFF_FFFC, 64);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (rom_en !== 1'b1 || rom_addr !== 14'h3FFF) begin n_fail++; $display("FAIL wrap32_a: got en=%b addr=%h, required 1/3fff", rom_en, rom_addr); end
    @(negedge clk);
    n_cmp++; if (rom_addr !== 14'h0) begin n_fail++; $display("FAIL wrap32_b: got addr=%h, required 0", rom_addr); end
    @(negedge clk);
    n_cmp++; if (inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap32_pc0: got %h, required fffffffc", inst_pc); end
    @(negedge clk);
    n_cmp++; if (inst_pc !== 32'h0 || inst !== 32'h1000_0000) begin n_fail++; $display("FAIL wrap32_pc1: got pc=%h inst=%h, required 0/10000000", inst_pc, inst); end
    // ROM word-address aliasing at the 2^ADDR_W boundary
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_FFF8;
    exp_q.delete(); push_seq(32'h0000_FFF8, 64);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (rom_addr !== 14'h3FFE) begin n_fail++; $display("FAIL alias_a: got %h, required 3ffe", rom_addr); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (rom_en !== 1'b1 || rom_addr !== 14'h0) begin n_fail++; $display("FAIL alias_b: got en=%b addr=%h, required 1/0", rom_en, rom_addr); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0 || rom_en !== 1'b0) begin n_fail++; $display("FAIL arst_now: got valid=%b en=%b, required 0/0", inst_valid, rom_en); end
    n_cmp++; if (inst_pc !== 32'h0 || inst !== 32'h0 || rom_addr !== 14'h0) begin n_fail++; $display("FAIL arst_vals: got pc=%h inst=%h addr=%h, required 0/0/0", inst_pc, inst, rom_addr); end
    exp_q.delete(); push_seq(32'h0, 64);
    #4 rst_n = 1'b1;
    @(negedge clk); // cycle 1
    n_cmp++; if (rom_en !== 1'b1 || rom_addr !== 14'h0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL arst_c1: got en=%b addr=%h valid=%b, required 1/0/0", rom_en, rom_addr, inst_valid); end
    @(negedge clk); // cycle 2
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL arst_c2: got valid=%b, required 0", inst_valid); end
    @(negedge clk); // cycle 3
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL arst_c3: got valid=%b pc=%h, required 1/0", inst_valid, inst_pc); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_back_to_back_redirect();
    test_wrap();
    test_async_reset();
    @(posedge clk); #1 inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
